branch_unit: RTL and testbench
==============================

# branch_unit

Execute-stage branch resolution unit: evaluates conditional branches, JAL and JALR, computes the redirect target and drives the fetch stage's branch-taken/branch-PC inputs. Registers the redirect for one cycle, then holds a flush for the wrong-path instructions already fetched. Also produces the link value and flags misaligned targets. Sits between decode/register-read and the fetch next-PC mux.

## Interface
- FLUSH_CYCLES, 2, cycles o_flush stays high per redirect, counting the o_b_taken cycle; legal 1..7
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  instruction in execute is valid
- i_stall  input  1  pipeline stall; freezes state, counters and outputs
- i_is_branch  input  1  conditional branch
- i_is_jal  input  1  JAL
- i_is_jalr  input  1  JALR
- i_funct3  input  3  branch condition
- i_rs1  input  32  operand 1
- i_rs2  input  32  operand 2
- i_pc  input  32  instruction PC
- i_imm  input  32  sign-extended immediate
- o_b_taken  output  1  redirect fetch, one cycle
- o_b_pc  output  32  redirect target
- o_flush  output  1  squash IF/ID wrong-path instructions
- o_link  output  32  i_pc+4 of the resolved JAL/JALR
- o_link_valid  output  1  o_link is to be written back, one cycle
- o_misalign  output  1  target misaligned, one cycle

## Operation
- States: IDLE, REDIRECT, FLUSH.
- Instruction accepted when i_valid=1, i_stall=0, o_flush=0; i_valid during o_flush is ignored (wrong path).
- Conditions by i_funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 are not taken.
- Targets: branch/JAL = i_pc+i_imm; JALR = (i_rs1+i_imm) with bit0 cleared. All sums mod 2^32, no overflow flag.
- Link: i_pc+4 mod 2^32.
- Taken = JAL, JALR, or branch with true condition. Priority if several type bits set: JALR > JAL > branch.
- Taken and target[1]=0: IDLE→REDIRECT; o_b_taken=1, o_b_pc=target, o_flush=1; JAL/JALR also o_link_valid=1.
- Taken and target[1]=1: no redirect, o_misalign=1, o_link_valid=0, stay IDLE; o_b_pc updated to faulting target.
- Not taken: stay IDLE, all pulses 0.
- REDIRECT→FLUSH if FLUSH_CYCLES>1, else →IDLE. FLUSH counts down; →IDLE after o_flush has been high FLUSH_CYCLES cycles total.
- o_b_pc and o_link hold last value between events.

## Timing
- Reset: state IDLE, o_b_taken=0, o_b_pc=0, o_flush=0, o_link=0, o_link_valid=0, o_misalign=0, flush counter 0.
- Latency 1 cycle: inputs sampled at edge N, outputs valid after edge N (registered); no combinational input→output path.
- o_b_taken, o_link_valid, o_misalign: single-cycle pulses unless stalled.
- i_stall=1: state, counter, every output held unchanged; a pending redirect stays asserted until the first unstalled cycle.
- Reset mid-redirect or mid-flush: immediate return to reset values; no residual flush after release.
- Next instruction accepted on the first cycle with o_flush=0.

## Configuration
- BRANCH_STATS_EN defined: adds outputs o_br_count[31:0] and o_br_taken_count[31:0]. Each accepted conditional branch increments o_br_count; each taken, aligned one also increments o_br_taken_count. Both reset to 0, wrap at 2^32, freeze on i_stall.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- BEQ, i_rs1=i_rs2=5, i_pc=0x100, i_imm=0x20 → next cycle o_b_taken=1, o_b_pc=0x120, o_flush=1 for 2 cycles (default).
- BLT vs BLTU, i_rs1=0xFFFFFFFF, i_rs2=1 → BLT taken, BLTU not taken (o_b_taken=0).
- JALR, i_rs1=0x201, i_imm=0x10, i_pc=0x40 → o_b_pc=0x210, o_link=0x44, o_link_valid=1; i_rs1=0x202 → o_misalign=1, o_b_taken=0.
- Taken branch followed by valid taken JAL in the two shadow cycles → JAL ignored, single o_b_taken pulse.
- i_stall=1 for 3 cycles during REDIRECT → o_b_taken, o_flush held, resume for remaining flush cycles after release.
- i_rst_n low mid-FLUSH → all outputs 0 asynchronously; with BRANCH_STATS_EN, 3 branches (2 taken) → counts 3/2.

Source files
------------

// File: rtl/branch_unit.sv
// Execute-stage branch resolution: evaluates branch/JAL/JALR, registers the fetch redirect and holds the wrong-path flush.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
`ifdef BRANCH_STATS_EN
    output logic [31:0] o_br_count,
    output logic [31:0] o_br_taken_count,
`endif
    output logic        o_b_taken,
    output logic [31:0] o_b_pc,
    output logic        o_flush,
    output logic [31:0] o_link,
    output logic        o_link_valid,
    output logic        o_misalign
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_taken_q, b_taken_d;
    logic [XLEN-1:0]  b_pc_q, b_pc_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  link_q, link_d;
    logic             link_valid_q, link_valid_d;
    logic             misalign_q, misalign_d;

    logic             cond_true;
    logic             is_jump;
    logic             is_cond;
    logic             taken;
    logic             accept;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  jalr_target;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link_sum;

    // Branch condition evaluation
    always_comb begin
        cond_true = 1'b0;
        case (i_funct3)
            3'b000:  cond_true = (i_rs1 == i_rs2);
            3'b001:  cond_true = (i_rs1 != i_rs2);
            3'b100:  cond_true = ($signed(i_rs1) <  $signed(i_rs2));
            3'b101:  cond_true = ($signed(i_rs1) >= $signed(i_rs2));
            3'b110:  cond_true = (i_rs1 <  i_rs2);
            3'b111:  cond_true = (i_rs1 >= i_rs2);
            default: cond_true = 1'b0;
        endcase
    end

    // Target, link and decode with JALR > JAL > branch priority
    always_comb begin
        br_target   = i_pc + i_imm;
        jalr_target = (i_rs1 + i_imm) & ~XLEN'(1);
        target      = i_is_jalr ? jalr_target : br_target;
        link_sum    = i_pc + XLEN'(4);
        is_jump     = i_is_jal | i_is_jalr;
        is_cond     = i_is_branch & ~is_jump;
        taken       = is_jump | (is_cond & cond_true);
        accept      = i_valid & ~i_stall & ~flush_q;
    end

    // Next-state and registered-output logic; a stall freezes everything
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        b_taken_d    = b_taken_q;
        b_pc_d       = b_pc_q;
        flush_d      = flush_q;
        link_d       = link_q;
        link_valid_d = link_valid_q;
        misalign_d   = misalign_q;

        if (!i_stall) begin
            b_taken_d    = 1'b0;
            link_valid_d = 1'b0;
            misalign_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && taken) begin
                        b_pc_d = target;
                        if (!target[1]) begin
                            state_d   = REDIRECT;
                            b_taken_d = 1'b1;
                            flush_d   = 1'b1;
                            if (is_jump) begin
                                link_valid_d = 1'b1;
                                link_d       = link_sum;
                            end
                        end else begin
                            misalign_d = 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 2);
                    end else begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            b_taken_q    <= 1'b0;
            b_pc_q       <= '0;
            flush_q      <= 1'b0;
            link_q       <= '0;
            link_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            b_taken_q    <= b_taken_d;
            b_pc_q       <= b_pc_d;
            flush_q      <= flush_d;
            link_q       <= link_d;
            link_valid_q <= link_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign o_b_taken    = b_taken_q;
    assign o_b_pc       = b_pc_q;
    assign o_flush      = flush_q;
    assign o_link       = link_q;
    assign o_link_valid = link_valid_q;
    assign o_misalign   = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] br_count_q, br_count_d;
    logic [XLEN-1:0] br_taken_count_q, br_taken_count_d;

    // Count accepted conditional branches and the aligned taken subset
    always_comb begin
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (accept && is_cond) begin
            br_count_d = br_count_q + XLEN'(1);
            if (cond_true && !target[1]) begin
                br_taken_count_d = br_taken_count_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            br_count_q       <= '0;
            br_taken_count_q <= '0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign o_br_count       = br_count_q;
    assign o_br_taken_count = br_taken_count_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, multi-cycle sequences and a randomized reference-model run.
module tb_branch_unit;

    localparam int unsigned FC = 2;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_stall;
    logic        i_is_branch;
    logic        i_is_jal;
    logic        i_is_jalr;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] i_pc;
    logic [31:0] i_imm;
    logic        o_b_taken;
    logic [31:0] o_b_pc;
    logic        o_flush;
    logic [31:0] o_link;
    logic        o_link_valid;
    logic        o_misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] o_br_count;
    logic [31:0] o_br_taken_count;
`endif

    branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .i_stall         (i_stall),
        .i_is_branch     (i_is_branch),
        .i_is_jal        (i_is_jal),
        .i_is_jalr       (i_is_jalr),
        .i_funct3        (i_funct3),
        .i_rs1           (i_rs1),
        .i_rs2           (i_rs2),
        .i_pc            (i_pc),
        .i_imm           (i_imm),
`ifdef BRANCH_STATS_EN
        .o_br_count      (o_br_count),
        .o_br_taken_count(o_br_taken_count),
`endif
        .o_b_taken       (o_b_taken),
        .o_b_pc          (o_b_pc),
        .o_flush         (o_flush),
        .o_link          (o_link),
        .o_link_valid    (o_link_valid),
        .o_misalign      (o_misalign)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: remaining flush cycles tracked as a plain integer
    logic        m_taken, m_flush, m_lv, m_mis;
    logic [31:0] m_pc, m_link, m_cnt, m_tcnt;
    int          m_rem;

    task automatic model_clear();
        m_taken = 0; m_flush = 0; m_lv = 0; m_mis = 0;
        m_pc = 0; m_link = 0; m_cnt = 0; m_tcnt = 0; m_rem = 0;
    endtask

    function automatic logic cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        logic        tk;
        logic        jump;
        if (i_stall) return;
        m_taken = 0; m_lv = 0; m_mis = 0;
        if (m_flush) begin
            if (m_rem > 0) m_rem--;
            else m_flush = 0;
        end else if (i_valid) begin
            jump = i_is_jal || i_is_jalr;
            if (i_is_jalr) tgt = (i_rs1 + i_imm) - ((i_rs1 + i_imm) % 2);
            else           tgt = i_pc + i_imm;
            tk = jump || (i_is_branch && cond_of(i_funct3, i_rs1, i_rs2));
            if (i_is_branch && !jump) begin
                m_cnt++;
                if (tk && (tgt % 4) < 2) m_tcnt++;
            end
            if (tk) begin
                m_pc = tgt;
                if ((tgt % 4) < 2) begin
                    m_taken = 1; m_flush = 1; m_rem = FC - 1;
                    if (jump) begin m_lv = 1; m_link = i_pc + 4; end
                end else begin
                    m_mis = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_stall = 0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
        i_funct3 = 0; i_rs1 = 0; i_rs2 = 0; i_pc = 0; i_imm = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 0;
        #12;
        @(negedge i_clk);
        i_rst_n = 1;
        model_clear();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm);
        i_valid = 1; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr;
        i_funct3 = f3; i_rs1 = rs1; i_rs2 = rs2; i_pc = pc; i_imm = imm;
    endtask

    typedef struct {
        string       name;
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        e_taken;
        logic [31:0] e_pc;
        logic [31:0] e_link;
        logic        e_lv, e_mis;
    } vec_t;

    function automatic vec_t mk(input string n, input logic br, input logic jal, input logic jalr,
                                input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm, input logic et,
                                input logic [31:0] epc, input logic [31:0] elink,
                                input logic elv, input logic emis);
        vec_t v;
        v.name = n; v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
        v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
        v.e_taken = et; v.e_pc = epc; v.e_link = elink; v.e_lv = elv; v.e_mis = emis;
        return v;
    endfunction

    vec_t vecs[14];
    int   pulses;

    initial begin
        idle_inputs();
        i_rst_n = 0;
        model_clear();
        #3;
        chk("rst_taken", 32'(o_b_taken), 0);
        chk("rst_pc",    o_b_pc, 0);
        chk("rst_flush", 32'(o_flush), 0);
        chk("rst_link",  o_link, 0);
        chk("rst_lv",    32'(o_link_valid), 0);
        chk("rst_mis",   32'(o_misalign), 0);
        do_reset();

        // b_pc and link expectations carry history from earlier rows
        vecs[0]  = mk("beq",       1,0,0, 3'd0, 32'd5,        32'd5,        32'h100, 32'h20,       1, 32'h120,  32'h0,   0, 0);
        vecs[1]  = mk("blt",       1,0,0, 3'd4, 32'hFFFFFFFF, 32'd1,        32'h200, 32'h40,       1, 32'h240,  32'h0,   0, 0);
        vecs[2]  = mk("bltu",      1,0,0, 3'd6, 32'hFFFFFFFF, 32'd1,        32'h200, 32'h40,       0, 32'h240,  32'h0,   0, 0);
        vecs[3]  = mk("jalr",      0,0,1, 3'd0, 32'h201,      32'd0,        32'h40,  32'h10,       1, 32'h210,  32'h44,  1, 0);
        vecs[4]  = mk("jalr_mis",  0,0,1, 3'd0, 32'h202,      32'd0,        32'h40,  32'h10,       0, 32'h212,  32'h44,  0, 1);
        vecs[5]  = mk("bne_nt",    1,0,0, 3'd1, 32'd3,        32'd3,        32'h0,   32'h0,        0, 32'h212,  32'h44,  0, 0);
        vecs[6]  = mk("f3_010",    1,0,0, 3'd2, 32'd1,        32'd2,        32'h300, 32'h8,        0, 32'h212,  32'h44,  0, 0);
        vecs[7]  = mk("bge",       1,0,0, 3'd5, 32'd1,        32'hFFFFFFFF, 32'h300, 32'hFFFFFFF8, 1, 32'h2F8,  32'h44,  0, 0);
        vecs[8]  = mk("bgeu_nt",   1,0,0, 3'd7, 32'd1,        32'hFFFFFFFF, 32'h300, 32'hFFFFFFF8, 0, 32'h2F8,  32'h44,  0, 0);
        vecs[9]  = mk("jal_wrap",  0,1,0, 3'd0, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h8,   1, 32'h4,    32'h0,   1, 0);
        vecs[10] = mk("prio_jalr", 1,1,1, 3'd1, 32'h1000,     32'h1000,     32'h500, 32'h4,        1, 32'h1004, 32'h504, 1, 0);
        vecs[11] = mk("prio_jal",  1,1,0, 3'd2, 32'd0,        32'd0,        32'h600, 32'h100,      1, 32'h700,  32'h604, 1, 0);
        vecs[12] = mk("br_mis",    1,0,0, 3'd0, 32'd7,        32'd7,        32'h100, 32'h2,        0, 32'h102,  32'h604, 0, 1);
        vecs[13] = mk("jalr_bit0", 0,0,1, 3'd0, 32'h801,      32'd0,        32'h10,  32'h4,        1, 32'h804,  32'h14,  1, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].br, vecs[k].jal, vecs[k].jalr, vecs[k].f3,
                  vecs[k].rs1, vecs[k].rs2, vecs[k].pc, vecs[k].imm);
            tick();
            idle_inputs();
            chk({vecs[k].name, "_taken"}, 32'(o_b_taken),    32'(vecs[k].e_taken));
            chk({vecs[k].name, "_pc"},    o_b_pc,            vecs[k].e_pc);
            chk({vecs[k].name, "_flush"}, 32'(o_flush),      32'(vecs[k].e_taken));
            chk({vecs[k].name, "_link"},  o_link,            vecs[k].e_link);
            chk({vecs[k].name, "_lv"},    32'(o_link_valid), 32'(vecs[k].e_lv));
            chk({vecs[k].name, "_mis"},   32'(o_misalign),   32'(vecs[k].e_mis));
            for (int c = 0; c < int'(FC); c++) tick();
            chk({vecs[k].name, "_done"},  32'(o_flush),      0);
        end

        // Valid JAL in the two shadow cycles must be ignored
        do_reset();
        pulses = 0;
        drive(1,0,0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20);
        tick();
        if (o_b_taken) pulses++;
        chk("shadow_flush0", 32'(o_flush), 1);
        drive(0,1,0, 3'd0, 32'd0, 32'd0, 32'h800, 32'h40);
        tick();
        if (o_b_taken) pulses++;
        chk("shadow_flush1", 32'(o_flush), 1);
        tick();
        if (o_b_taken) pulses++;
        chk("shadow_flush2", 32'(o_flush), 0);
        chk("shadow_pc",     o_b_pc, 32'h120);
        chk("shadow_lv",     32'(o_link_valid), 0);
        idle_inputs();
        tick();
        if (o_b_taken) pulses++;
        chk("shadow_pulses", 32'(pulses), 1);

        // Stall for three cycles while the redirect is pending
        do_reset();
        drive(1,0,0, 3'd0, 32'd9, 32'd9, 32'h400, 32'h80);
        tick();
        idle_inputs();
        i_stall = 1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_taken", 32'(o_b_taken), 1);
            chk("stall_flush", 32'(o_flush), 1);
            chk("stall_pc",    o_b_pc, 32'h480);
        end
        i_stall = 0;
        tick();
        chk("unstall_taken", 32'(o_b_taken), 0);
        chk("unstall_flush", 32'(o_flush), 1);
        tick();
        chk("unstall_done",  32'(o_flush), 0);

        // Asynchronous reset in the middle of the flush
        do_reset();
        drive(0,1,0, 3'd0, 32'd0, 32'd0, 32'h100, 32'h40);
        tick();
        idle_inputs();
        tick();
        chk("mid_flush", 32'(o_flush), 1);
        #2;
        i_rst_n = 0;
        #1;
        chk("arst_flush", 32'(o_flush), 0);
        chk("arst_pc",    o_b_pc, 0);
        chk("arst_link",  o_link, 0);
        @(negedge i_clk);
        i_rst_n = 1;
        model_clear();
        tick();
        chk("arst_after_flush", 32'(o_flush), 0);
        chk("arst_after_taken", 32'(o_b_taken), 0);

`ifdef BRANCH_STATS_EN
        do_reset();
        drive(1,0,0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20);
        tick(); idle_inputs(); tick(); tick();
        drive(1,0,0, 3'd1, 32'd5, 32'd5, 32'h100, 32'h20);
        tick(); idle_inputs(); tick();
        drive(1,0,0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20);
        tick(); idle_inputs(); tick(); tick();
        drive(0,1,0, 3'd0, 32'd0, 32'd0, 32'h100, 32'h20);
        tick(); idle_inputs(); tick(); tick();
        chk("stats_count", o_br_count, 32'd3);
        chk("stats_taken", o_br_taken_count, 32'd2);
`endif

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            i_valid     = ($urandom_range(0, 9) < 6);
            i_stall     = ($urandom_range(0, 9) < 2);
            i_is_branch = $urandom_range(0, 1);
            i_is_jal    = ($urandom_range(0, 5) == 0);
            i_is_jalr   = ($urandom_range(0, 5) == 0);
            i_funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: i_rs1 = 32'd0;
                1: i_rs1 = 32'd1;
                2: i_rs1 = 32'hFFFFFFFF;
                default: i_rs1 = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: i_rs2 = 32'd0;
                1: i_rs2 = 32'd1;
                2: i_rs2 = 32'hFFFFFFFF;
                default: i_rs2 = i_rs1;
            endcase
            i_pc  = $urandom & 32'hFFFFFFFC;
            i_imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
            tick();
            chk("rnd_taken", 32'(o_b_taken),    32'(m_taken));
            chk("rnd_pc",    o_b_pc,            m_pc);
            chk("rnd_flush", 32'(o_flush),      32'(m_flush));
            chk("rnd_link",  o_link,            m_link);
            chk("rnd_lv",    32'(o_link_valid), 32'(m_lv));
            chk("rnd_mis",   32'(o_misalign),   32'(m_mis));
`ifdef BRANCH_STATS_EN
            chk("rnd_cnt",   o_br_count,        m_cnt);
            chk("rnd_tcnt",  o_br_taken_count,  m_tcnt);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
